// File: rtl/tank_shell_if.sv
`default_nettype none
// ============================================================================
// Module   : tank_shell_if
// Brief    : Barrel/fire inputs and shell position outputs of tank_shell.
// Revision : 1.0 - initial release
// ============================================================================
interface tank_shell_if;
    logic       fire;
    logic       hit;
    logic [9:0] BarrelX;
    logic [9:0] BarrelY;
    logic [1:0] p_direction;
    logic [9:0] ShellX;
    logic [9:0] ShellY;
    logic [9:0] Shell_Size;
    logic       shell_active;
    logic [1:0] shell_dir;
    logic       ready;

    modport master (
        output fire, hit, BarrelX, BarrelY, p_direction,
        input  ShellX, ShellY, Shell_Size, shell_active, shell_dir, ready
    );

    modport slave (
        input  fire, hit, BarrelX, BarrelY, p_direction,
        output ShellX, ShellY, Shell_Size, shell_active, shell_dir, ready
    );
endinterface
`default_nettype wire

// File: rtl/tank_shell.sv
`default_nettype none
// ============================================================================
// Module   : tank_shell
// Brief    : Single-shell projectile controller: launch, flight, cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module tank_shell #(
    parameter int SHELL_SPEED     = 4,
    parameter int SHELL_SIZE      = 2,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479
) (
    input  wire logic    frame_clk,
    input  wire logic    Reset,
    tank_shell_if.slave  bus
);

    localparam int          c_cnt_w    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(COOLDOWN_FRAMES - 1);
    localparam logic [10:0] c_x_min    = 11'(X_MIN);
    localparam logic [10:0] c_x_max    = 11'(X_MAX);
    localparam logic [10:0] c_y_min    = 11'(Y_MIN);
    localparam logic [10:0] c_y_max    = 11'(Y_MAX);
    localparam logic [10:0] c_speed11  = 11'(SHELL_SPEED);
    localparam logic [9:0]  c_speed10  = 10'(SHELL_SPEED);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLIGHT   = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_fire_q;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [9:0]           r_x;
    logic [9:0]           r_y;
    logic [1:0]           r_dir;
    logic                 r_active;
    logic                 r_ready;

    logic                 w_fire_rise;
    logic                 w_barrel_ok;
    logic                 w_exit;
    logic                 w_launch;
    logic                 w_step;
    logic                 w_cnt_load;
    logic [10:0]          w_bx;
    logic [10:0]          w_by;
    logic [10:0]          w_sx;
    logic [10:0]          w_sy;

    assign w_bx = {1'b0, bus.BarrelX};
    assign w_by = {1'b0, bus.BarrelY};
    assign w_sx = {1'b0, r_x};
    assign w_sy = {1'b0, r_y};

    assign w_fire_rise = bus.fire & ~r_fire_q;

    // "+1 > MIN" is the same as ">= MIN" but stays meaningful when MIN is 0
    assign w_barrel_ok = ((w_bx + 11'd1) > c_x_min) && (w_bx <= c_x_max) &&
                         ((w_by + 11'd1) > c_y_min) && (w_by <= c_y_max);

    // Exit test is done in 11 bits so the shell never wraps past an edge
    always_comb begin
        w_exit = 1'b0;
        case (r_dir)
            2'b00:   w_exit = (w_sx < (c_x_min + c_speed11));
            2'b01:   w_exit = ((w_sx + c_speed11) > c_x_max);
            2'b10:   w_exit = ((w_sy + c_speed11) > c_y_max);
            default: w_exit = (w_sy < (c_y_min + c_speed11));
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_launch   = 1'b0;
        w_step     = 1'b0;
        w_cnt_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire_rise && w_barrel_ok) begin
                    w_launch = 1'b1;
                    w_next   = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (bus.hit || w_exit) begin
                    w_cnt_load = 1'b1;
                    w_next     = S_COOLDOWN;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (r_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_fire_q <= 1'b1;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= 2'b00;
            r_active <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_fire_q <= bus.fire;
            r_active <= (w_next == S_FLIGHT);
            r_ready  <= (w_next == S_IDLE);

            if (w_cnt_load) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == S_COOLDOWN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            if (w_launch) begin
                r_x   <= bus.BarrelX;
                r_y   <= bus.BarrelY;
                r_dir <= bus.p_direction;
            end else if (w_step) begin
                case (r_dir)
                    2'b00:   r_x <= r_x - c_speed10;
                    2'b01:   r_x <= r_x + c_speed10;
                    2'b10:   r_y <= r_y + c_speed10;
                    default: r_y <= r_y - c_speed10;
                endcase
            end
        end
    end

    assign bus.ShellX       = r_x;
    assign bus.ShellY       = r_y;
    assign bus.Shell_Size   = 10'(SHELL_SIZE);
    assign bus.shell_active = r_active;
    assign bus.shell_dir    = r_dir;
    assign bus.ready        = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_tank_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_shell
// Brief    : Scoreboard bench for tank_shell with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_shell;

    localparam int SPEED = 4;
    localparam int SIZE  = 2;
    localparam int COOL  = 15;
    localparam int XMIN  = 0;
    localparam int XMAX  = 639;
    localparam int YMIN  = 0;
    localparam int YMAX  = 479;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] d;
        logic       act;
        logic       rdy;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;
    int   tests     = 0;
    int   fails     = 0;
    exp_t sb[$];

    tank_shell_if ifc ();

    tank_shell #(
        .SHELL_SPEED(SPEED), .SHELL_SIZE(SIZE), .COOLDOWN_FRAMES(COOL),
        .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (ifc)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference model: playfield position, remaining cooldown frames, key memory
    int   m_x, m_y, m_d, m_wait;
    bit   m_act, m_fq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_d = 0; m_wait = 0; m_act = 0; m_fq = 1;
    endtask

    // Drive one frame's inputs at a falling edge, predict the next rising edge
    task automatic step(input bit f, input bit h, input int bx, input int by, input int d);
        bit   rise;
        int   nx, ny;
        exp_t e;
        ifc.fire        = f;
        ifc.hit         = h;
        ifc.BarrelX     = 10'(bx);
        ifc.BarrelY     = 10'(by);
        ifc.p_direction = 2'(d);
        rise = f && !m_fq;
        m_fq = f;
        if (m_act) begin
            nx = m_x; ny = m_y;
            case (m_d)
                0: nx = m_x - SPEED;
                1: nx = m_x + SPEED;
                2: ny = m_y + SPEED;
                default: ny = m_y - SPEED;
            endcase
            if (h || nx < XMIN || nx > XMAX || ny < YMIN || ny > YMAX) begin
                m_act  = 0;
                m_wait = COOL;
            end else begin
                m_x = nx; m_y = ny;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (rise && bx >= XMIN && bx <= XMAX && by >= YMIN && by <= YMAX) begin
            m_x = bx; m_y = by; m_d = d; m_act = 1;
        end
        e.x = 10'(m_x); e.y = 10'(m_y); e.d = 2'(m_d);
        e.act = m_act; e.rdy = !m_act && (m_wait == 0);
        sb.push_back(e);
        @(negedge frame_clk);
    endtask

    // Asynchronous reset, checked before any clock edge can intervene
    task automatic do_reset(input bit f);
        ifc.fire = f;
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_x",     32'(ifc.ShellX), 0);
        chk("rst_y",     32'(ifc.ShellY), 0);
        chk("rst_dir",   32'(ifc.shell_dir), 0);
        chk("rst_act",   32'(ifc.shell_active), 0);
        chk("rst_ready", 32'(ifc.ready), 1);
        repeat (2) @(negedge frame_clk);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic idle_until_ready(input int bx, input int by);
        for (int i = 0; i < 400 && !(!m_act && m_wait == 0); i++)
            step(0, 0, bx, by, 1);
        step(0, 0, bx, by, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ShellX",       32'(ifc.ShellX), 32'(e.x));
                chk("ShellY",       32'(ifc.ShellY), 32'(e.y));
                chk("shell_dir",    32'(ifc.shell_dir), 32'(e.d));
                chk("shell_active", 32'(ifc.shell_active), 32'(e.act));
                chk("ready",        32'(ifc.ready), 32'(e.rdy));
                chk("Shell_Size",   32'(ifc.Shell_Size), SIZE);
            end
        end
    end

    initial begin : driver
        int bx, by, d, r;
        bit f, h;
        ifc.fire = 0; ifc.hit = 0; ifc.BarrelX = '0; ifc.BarrelY = '0; ifc.p_direction = '0;
        model_reset();
        @(negedge frame_clk);
        do_reset(0);

        // launch right from (100,200), fire held for a few frames
        step(0, 0, 100, 200, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 100, 200, 1);
        idle_until_ready(100, 200);

        // right-edge exit, then a fire edge during cooldown
        step(1, 0, 632, 100, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 632, 100, 1);
        step(1, 0, 632, 100, 1);
        step(0, 0, 632, 100, 1);
        idle_until_ready(632, 100);

        // left underflow from x=3, then a wrapped barrel coordinate
        step(1, 0, 3, 240, 0);
        step(0, 0, 3, 240, 0);
        idle_until_ready(3, 240);
        step(1, 0, 1020, 240, 1);
        step(0, 0, 1020, 240, 1);
        step(1, 0, 50, 1000, 3);
        step(0, 0, 50, 1000, 3);

        // hit and bottom exit on the same frame
        step(1, 0, 300, 476, 2);
        step(0, 1, 300, 476, 2);
        step(0, 0, 300, 476, 2);
        idle_until_ready(300, 476);

        // direction changes mid-flight, then hit and reset mid-cooldown
        step(1, 0, 10, 10, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 10, 10, i % 4);
        step(0, 1, 10, 10, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 10, 10, 2);
        do_reset(0);

        // fire held across reset must not launch until released and pressed again
        step(1, 0, 200, 200, 3);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, 0, 200, 200, 3);
        step(0, 0, 200, 200, 3);
        step(1, 0, 200, 200, 3);
        idle_until_ready(200, 200);

        // randomized traffic
        f = 0; d = 1; bx = 320; by = 240;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) f = !f;
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r == 0)      bx = int'($urandom_range(640, 1023));
            else if (r < 3)  bx = int'($urandom_range(620, 639));
            else if (r < 5)  bx = int'($urandom_range(0, 12));
            else             bx = int'($urandom_range(0, 639));
            r = int'($urandom_range(0, 9));
            if (r == 0)      by = int'($urandom_range(480, 1023));
            else if (r < 3)  by = int'($urandom_range(460, 479));
            else if (r < 5)  by = int'($urandom_range(0, 12));
            else             by = int'($urandom_range(0, 479));
            h = m_act && ($urandom_range(0, 24) == 0);
            step(f, h, bx, by, d);
        end
        step(0, 0, 0, 0, 0);

        @(posedge frame_clk);
        #4;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
